// File: rtl/fp_multiplier_pipe.sv
// Pipelined floating-point multiplier with configurable exponent and fraction
// widths. Rounding is round-to-nearest-even. Denormal inputs are flushed to
// zero and no denormals are produced. Four register ranks are used: unpack,
// multiply, normalise, then round/pack into the output register. The design
// uses a valid/ready handshake with a global enable. Bubbles travel with the
// data and are not collapsed.
module fp_multiplier_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     inputA,
  input  logic [EXP_W+MAN_W:0]     inputB,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     OF,
  output logic                     UF
);

  localparam int EW2  = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  localparam logic signed [EW2-1:0] BIAS_S = EW2'(BIAS);
  localparam logic signed [EW2-1:0] EMAX_S = EW2'(EMAX);

  // Stage valid bits and output registers
  logic r_s1_valid, r_s2_valid, r_s3_valid, r_out_valid;
  logic [EXP_W+MAN_W:0] r_result;
  logic r_of, r_uf;

  // Stage 1 unpack registers
  logic                  r_s1_sign, r_s1_nan, r_s1_inf, r_s1_zero;
  logic signed [EW2-1:0] r_s1_esum;
  logic [MAN_W:0]        r_s1_ma, r_s1_mb;

  // Stage 2 product registers
  logic                  r_s2_sign, r_s2_nan, r_s2_inf, r_s2_zero;
  logic signed [EW2-1:0] r_s2_esum;
  logic [PW-1:0]         r_s2_prod;

  // Stage 3 normalise registers
  logic                  r_s3_sign, r_s3_nan, r_s3_inf, r_s3_zero;
  logic signed [EW2-1:0] r_s3_esum;
  logic [MAN_W:0]        r_s3_mant;
  logic                  r_s3_guard, r_s3_sticky;

  // A stalled output blocks the whole pipe; en overrides out_ready.
  logic w_advance;
  assign w_advance = en && (!r_out_valid || out_ready);
  assign in_ready  = w_advance && reset;

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign OF        = r_of;
  assign UF        = r_uf;

  // Stage 1 combinational: operand field extraction and classification
  logic                  w_sign_a, w_sign_b;
  logic [EXP_W-1:0]      w_exp_a, w_exp_b;
  logic [MAN_W-1:0]      w_frac_a, w_frac_b;
  logic                  w_zero_a, w_zero_b, w_nan_a, w_nan_b, w_inf_a, w_inf_b;
  logic signed [EW2-1:0] w_esum;

  assign {w_sign_a, w_exp_a, w_frac_a} = inputA;
  assign {w_sign_b, w_exp_b, w_frac_b} = inputB;
  // Any zero exponent counts as zero, so denormal inputs flush here.
  assign w_zero_a = (w_exp_a == '0);
  assign w_zero_b = (w_exp_b == '0);
  assign w_nan_a  = (w_exp_a == '1) && (w_frac_a != '0);
  assign w_nan_b  = (w_exp_b == '1) && (w_frac_b != '0);
  assign w_inf_a  = (w_exp_a == '1) && (w_frac_a == '0);
  assign w_inf_b  = (w_exp_b == '1) && (w_frac_b == '0);
  assign w_esum   = $signed({2'b00, w_exp_a}) + $signed({2'b00, w_exp_b}) - BIAS_S;

  // Stage 3 combinational: one-bit normalisation plus guard/sticky extraction
  logic                  w_norm_hi;
  logic [MAN_W:0]        w_norm_mant;
  logic                  w_norm_guard, w_norm_sticky;
  logic signed [EW2-1:0] w_norm_esum;

  assign w_norm_hi     = r_s2_prod[PW-1];
  assign w_norm_mant   = w_norm_hi ? r_s2_prod[PW-1:MAN_W+1] : r_s2_prod[PW-2:MAN_W];
  assign w_norm_guard  = w_norm_hi ? r_s2_prod[MAN_W] : r_s2_prod[MAN_W-1];
  assign w_norm_sticky = w_norm_hi ? (|r_s2_prod[MAN_W-1:0]) : (|r_s2_prod[MAN_W-2:0]);
  assign w_norm_esum   = r_s2_esum + $signed({{(EW2-1){1'b0}}, w_norm_hi});

  // Output combinational: round-to-nearest-even, renormalise on carry, then pack
  logic                  w_round_up, w_carry;
  logic [MAN_W+1:0]      w_rsum;
  logic [MAN_W-1:0]      w_frac;
  logic signed [EW2-1:0] w_esum_f;
  logic [EXP_W+MAN_W:0]  w_res;
  logic                  w_of, w_uf;

  assign w_round_up = r_s3_guard && (r_s3_sticky || r_s3_mant[0]);
  assign w_rsum     = {1'b0, r_s3_mant} + (MAN_W+2)'(w_round_up);
  assign w_carry    = w_rsum[MAN_W+1];
  assign w_frac     = w_carry ? w_rsum[MAN_W:1] : w_rsum[MAN_W-1:0];
  assign w_esum_f   = r_s3_esum + $signed({{(EW2-1){1'b0}}, w_carry});

  // Special-case priority: NaN, infinity, zero, overflow, underflow, normal
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_res = {r_s3_sign, w_esum_f[EXP_W-1:0], w_frac};
    w_of  = 1'b0;
    w_uf  = 1'b0;
    if (r_s3_nan) begin
      w_res = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
    end else if (r_s3_inf) begin
      w_res = {r_s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (r_s3_zero) begin
      w_res = {r_s3_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    end else if (w_esum_f >= EMAX_S) begin
      w_res = {r_s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_of  = 1'b1;
    end else if (w_esum_f <= '0) begin
      w_res = {r_s3_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      w_uf  = 1'b1;
    end
  end

  // Control path: valid bits and output register, cleared by reset, held on stall
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    if (!reset) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s3_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_of        <= 1'b0;
      r_uf        <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid  <= in_valid;
      r_s2_valid  <= r_s1_valid;
      r_s3_valid  <= r_s2_valid;
      r_out_valid <= r_s3_valid;
      r_result    <= w_res;
      r_of        <= w_of;
      r_uf        <= w_uf;
    end
  end

  // Datapath stage registers, gated only by advance
  always_ff @(posedge clk) begin
    // NOTE: payload registers skip reset; the valid bits alone say whether they mean anything.
    if (w_advance) begin
      r_s1_sign   <= w_sign_a ^ w_sign_b;
      r_s1_nan    <= w_nan_a || w_nan_b || (w_zero_a && w_inf_b) || (w_inf_a && w_zero_b);
      r_s1_inf    <= w_inf_a || w_inf_b;
      r_s1_zero   <= w_zero_a || w_zero_b;
      r_s1_esum   <= w_esum;
      r_s1_ma     <= {1'b1, w_frac_a};
      r_s1_mb     <= {1'b1, w_frac_b};

      r_s2_sign   <= r_s1_sign;
      r_s2_nan    <= r_s1_nan;
      r_s2_inf    <= r_s1_inf;
      r_s2_zero   <= r_s1_zero;
      r_s2_esum   <= r_s1_esum;
      r_s2_prod   <= PW'(r_s1_ma) * PW'(r_s1_mb);

      r_s3_sign   <= r_s2_sign;
      r_s3_nan    <= r_s2_nan;
      r_s3_inf    <= r_s2_inf;
      r_s3_zero   <= r_s2_zero;
      r_s3_esum   <= w_norm_esum;
      r_s3_mant   <= w_norm_mant;
      r_s3_guard  <= w_norm_guard;
      r_s3_sticky <= w_norm_sticky;
    end
  end

endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// Directed testbench for fp_multiplier_pipe. It exercises a single-precision
// instance and a half-precision instance (EXP_W=5, MAN_W=10). Expected values
// are hand-computed constants.
module tb_fp_multiplier_pipe;

  logic        clk = 1'b0;
  logic        reset, en, out_ready;
  logic        in_valid, in_ready, out_valid, of_f, uf_f;
  logic [31:0] in_a, in_b, result;
  logic        h_in_valid, h_in_ready, h_out_valid, h_of, h_uf;
  logic [15:0] h_a, h_b, h_result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_multiplier_pipe dut (
    .clk(clk), .reset(reset), .en(en),
    .in_valid(in_valid), .in_ready(in_ready),
    .inputA(in_a), .inputB(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .OF(of_f), .UF(uf_f)
  );

  fp_multiplier_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .reset(reset), .en(en),
    .in_valid(h_in_valid), .in_ready(h_in_ready),
    .inputA(h_a), .inputB(h_b),
    .out_valid(h_out_valid), .out_ready(out_ready),
    .result(h_result), .OF(h_of), .UF(h_uf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Send one operand pair, wait for its result, check latency, value and flags.
  task automatic run_vec(input string tag, input bit half, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input logic exp_of, input logic exp_uf);
    int edges;
    @(negedge clk);
    if (half) begin h_a = a[15:0]; h_b = b[15:0]; h_in_valid = 1'b1; end
    else      begin in_a = a;      in_b = b;      in_valid   = 1'b1; end
    #1;
    check({tag, ".ready"}, half ? h_in_ready : in_ready, 1);
    @(posedge clk); #1;
    in_valid   = 1'b0;
    h_in_valid = 1'b0;
    edges = 0;
    while (!(half ? h_out_valid : out_valid) && edges < 10) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, ".latency"}, edges, 3);
    check({tag, ".result"}, half ? {16'h0, h_result} : result, exp_r);
    check({tag, ".OF"}, half ? h_of : of_f, exp_of);
    check({tag, ".UF"}, half ? h_uf : uf_f, exp_uf);
  endtask

  // Eight back-to-back pairs k*2.0 with out_ready cycling 1,0,0,1.
  task automatic stream_test();
    logic [31:0] st_a[8]   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] st_exp[8] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                               32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};
    bit          pat[4]    = '{1'b1, 1'b0, 1'b0, 1'b1};
    int          sent = 0, got = 0, cyc = 0;
    bit          held = 1'b0;
    logic [31:0] held_val = '0;
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 8);
      if (sent < 8) begin in_a = st_a[sent]; in_b = 32'h40000000; end
      #1;
      if (held) check("stream.hold", result, held_val);
      held = 1'b0;
      if (out_valid && out_ready) begin
        check("stream.result", result, st_exp[got]);
        got++;
      end else if (out_valid) begin
        check("stream.stall_ready", in_ready, 0);
        held     = 1'b1;
        held_val = result;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      cyc++;
    end
    check("stream.count", got, 8);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int edges;
    reset = 1'b0; en = 1'b1; out_ready = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0;
    h_in_valid = 1'b0; h_a = '0; h_b = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.in_ready", in_ready, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.result", result, 0);
    check("rst.OF", of_f, 0);
    check("rst.UF", uf_f, 0);
    reset = 1'b1;
    #1;
    check("rst.release_ready", in_ready, 1);

    // Single precision
    run_vec("mul_1p5x2",    0, 32'h3FC00000, 32'h40000000, 32'h40400000, 0, 0);
    run_vec("neg_sign",     0, 32'hBFC00000, 32'h40200000, 32'hC0700000, 0, 0);
    run_vec("tie_even",     0, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 0, 0);
    run_vec("zero_x_inf",   0, 32'h00000000, 32'h7F800000, 32'h7FFFFFFF, 0, 0);
    run_vec("neg_x_zero",   0, 32'hC2443852, 32'h00000000, 32'h80000000, 0, 0);
    run_vec("inf_x_num",    0, 32'h7F800000, 32'h60ADE3D6, 32'h7F800000, 0, 0);
    run_vec("nan_x_num",    0, 32'h7FFFFFFF, 32'h60ADE3D6, 32'h7FFFFFFF, 0, 0);
    run_vec("overflow",     0, 32'h7F000000, 32'h40000000, 32'h7F800000, 1, 0);
    run_vec("underflow",    0, 32'h00800000, 32'h3F000000, 32'h00000000, 0, 1);

    // Half precision
    run_vec("h_1p5x2",      1, 32'h3E00, 32'h4000, 32'h4200, 0, 0);
    run_vec("h_overflow",   1, 32'h7800, 32'h4000, 32'h7C00, 1, 0);

    // Backpressure stream
    stream_test();

    // en=0 freezes an in-flight operation
    @(negedge clk);
    in_a = 32'h40400000; in_b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; en = 1'b0;
    #1;
    check("en.in_ready", in_ready, 0);
    repeat (6) @(posedge clk);
    #1;
    check("en.frozen", out_valid, 0);
    @(negedge clk);
    en = 1'b1;
    edges = 0;
    while (!out_valid && edges < 10) begin
      @(posedge clk); #1;
      edges++;
    end
    check("en.latency", edges, 3);
    check("en.result", result, 32'h40C00000);

    // Reset mid-stream discards in-flight work
    @(negedge clk);
    in_a = 32'h40000000; in_b = 32'h40000000; in_valid = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("midrst.full", out_valid, 1);
    in_valid = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    check("midrst.out_valid", out_valid, 0);
    check("midrst.in_ready", in_ready, 0);
    check("midrst.result", result, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst.release_ready", in_ready, 1);
    repeat (6) @(posedge clk);
    #1;
    check("midrst.discarded", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
